// File: rtl/offset_add_pkg.sv
// Shared types and offset derivation for the offset_add_sched block.
// The per-requester offsets all come from off_of().
package offset_add_pkg;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FULL  = 2'd1,
    STALL = 2'd2
  } state_e;

  function automatic integer off_of(input integer idx, input integer p);
    integer r;
    case (idx)
      0:       r = 42;
      1:       r = p + 42;
      2:       r = p;
      default: r = ((p + 13) - 37) ^ (p + 13);
    endcase
    return r;
  endfunction

endpackage

// File: rtl/offset_add_sched_rr_arbiter4.sv
// Four-way round-robin arbiter, purely combinational.
// Scans req starting at ptr and grants the first valid one when en.
module rr_arbiter4
  import offset_add_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  input  logic       en,
  output logic [3:0] grant,
  output logic [1:0] gidx
);

  logic       found;
  logic [1:0] idx;

  always_comb begin
    grant = '0;
    gidx  = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < NREQ; k++) begin
      idx = ptr + 2'(k);
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

endmodule

// File: rtl/offset_add_sched.sv
// Shared constant-offset adder for four requesters, one-entry output stage.
// Build option OFFSET_ADD_SATURATE_EN: saturating add plus sticky sat_flag.
module offset_add_sched
  import offset_add_pkg::*;
#(
  parameter int P = 23,
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [3:0]      req_valid,
  input  logic [4*W-1:0]  req_data,
  output logic [3:0]      req_ready,
  output logic            res_valid,
  output logic [W-1:0]    res_data,
  output logic [1:0]      res_id,
  input  logic            res_ready,
`ifdef OFFSET_ADD_SATURATE_EN
  output logic            sat_flag,
`endif
  output logic            busy
);

  localparam logic [W-1:0] OFFS [NREQ] = '{
    W'(off_of(0, P)),
    W'(off_of(1, P)),
    W'(off_of(2, P)),
    W'(off_of(3, P))
  };

  state_e         state_q, state_d;
  logic [1:0]     rr_ptr_q, rr_ptr_d;
  logic [W-1:0]   res_data_q, res_data_d;
  logic [1:0]     res_id_q, res_id_d;

  logic           can_accept;
  logic [3:0]     grant;
  logic [1:0]     gidx;
  logic           xfer;
  logic [W-1:0]   operand;
  logic [W-1:0]   off;
  logic [W-1:0]   sum;

  assign res_valid  = (state_q != IDLE);
  assign can_accept = !res_valid || res_ready;

  rr_arbiter4 u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_q),
    .en    (can_accept),
    .grant (grant),
    .gidx  (gidx)
  );

  assign req_ready = rst_n ? grant : 4'b0000;
  assign xfer      = |grant;

  always_comb begin
    operand = '0;
    off     = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gidx == 2'(i)) begin
        operand = req_data[i*W +: W];
        off     = OFFS[i];
      end
    end
  end

`ifdef OFFSET_ADD_SATURATE_EN
  logic [W:0] sum_w;
  logic       carry;
  logic       sat_flag_q, sat_flag_d;

  assign sum_w = {1'b0, operand} + {1'b0, off};
  assign carry = sum_w[W];
  assign sum   = carry ? {W{1'b1}} : sum_w[W-1:0];

  always_comb begin
    sat_flag_d = sat_flag_q | (xfer & carry);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sat_flag_q <= 1'b0;
    else        sat_flag_q <= sat_flag_d;
  end

  assign sat_flag = sat_flag_q;
`else
  assign sum = operand + off;
`endif

  always_comb begin
    res_data_d = res_data_q;
    res_id_d   = res_id_q;
    rr_ptr_d   = rr_ptr_q;
    state_d    = IDLE;
    if (xfer) begin
      res_data_d = sum;
      res_id_d   = gidx;
      rr_ptr_d   = gidx + 2'd1;
      state_d    = FULL;
    end else if (res_valid && !res_ready) begin
      state_d = STALL;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      res_data_q <= '0;
      res_id_q   <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      res_data_q <= res_data_d;
      res_id_q   <= res_id_d;
    end
  end

  assign res_data = res_data_q;
  assign res_id   = res_id_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_offset_add_sched.sv
// Bench for offset_add_sched: directed scenarios plus random traffic
// against a transaction-level model of the arbiter and output register.
module tb_offset_add_sched;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  req_valid = '0;
  logic [31:0] req_data = '0;
  logic [3:0]  req_ready;
  logic        res_valid;
  logic [7:0]  res_data;
  logic [1:0]  res_id;
  logic        res_ready = 1'b0;
  logic        busy;
`ifdef OFFSET_ADD_SATURATE_EN
  logic        sat_flag;
`endif

  offset_add_sched #(.P(23), .W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .res_valid (res_valid),
    .res_data  (res_data),
    .res_id    (res_id),
    .res_ready (res_ready),
`ifdef OFFSET_ADD_SATURATE_EN
    .sat_flag  (sat_flag),
`endif
    .busy      (busy)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  logic [7:0] offs [4] = '{8'h2A, 8'h41, 8'h17, 8'hDB};

  bit         m_valid;
  logic [7:0] m_data;
  int         m_id;
  int         m_ptr;
  bit         m_sat;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_valid = 0;
    m_data  = 8'h00;
    m_id    = 0;
    m_ptr   = 0;
    m_sat   = 0;
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    res_ready = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cycle(input logic [3:0] v, input logic [31:0] d,
                       input logic r);
    int g;
    int s;
    logic [3:0] er;
    req_valid = v;
    req_data  = d;
    res_ready = r;
    #1;
    g  = -1;
    er = '0;
    if (!m_valid || r) begin
      for (int k = 0; k < 4; k++) begin
        int idx;
        idx = (m_ptr + k) % 4;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    if (g >= 0) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    @(posedge clk);
    #1;
    if (g >= 0) begin
      s = int'(d[g*8 +: 8]) + int'(offs[g]);
`ifdef OFFSET_ADD_SATURATE_EN
      if (s > 255) begin
        s = 255;
        m_sat = 1;
      end
`else
      s = s % 256;
`endif
      m_data  = 8'(s);
      m_id    = g;
      m_valid = 1;
      m_ptr   = (g + 1) % 4;
    end else if (r) begin
      m_valid = 0;
    end
    chk("res_valid", res_valid, m_valid);
    chk("busy", busy, m_valid);
    if (m_valid) begin
      chk("res_data", res_data, m_data);
      chk("res_id", res_id, m_id);
    end
`ifdef OFFSET_ADD_SATURATE_EN
    chk("sat_flag", sat_flag, m_sat);
`endif
  endtask

  initial begin
    model_reset();
    #2;
    chk("rst_valid", res_valid, 0);
    chk("rst_data", res_data, 0);
    chk("rst_id", res_id, 0);
    chk("rst_busy", busy, 0);
    req_valid = 4'hF;
    #1;
    chk("rst_req_ready", req_ready, 0);
    do_reset();

    // single request from requester 0
    cycle(4'b0001, 32'h0000_0010, 1'b1);
    chk("single_data", res_data, 8'h3A);
    chk("single_id", res_id, 0);
    cycle(4'b0000, 32'h0, 1'b1);

    // offset 3 and wrap/saturation cases
    cycle(4'b1000, 32'h3000_0000, 1'b1);
`ifdef OFFSET_ADD_SATURATE_EN
    chk("off3_data", res_data, 8'hFF);
`else
    chk("off3_data", res_data, 8'h0B);
`endif
    chk("off3_id", res_id, 3);
    cycle(4'b0010, 32'h0000_F000, 1'b1);
`ifdef OFFSET_ADD_SATURATE_EN
    chk("wrap_data", res_data, 8'hFF);
`else
    chk("wrap_data", res_data, 8'h31);
`endif
    cycle(4'b0000, 32'h0, 1'b1);

    // fairness from a fresh pointer
    do_reset();
    for (int i = 0; i < 5; i++) begin
      logic [7:0] fexp [5];
      fexp = '{8'h2A, 8'h41, 8'h17, 8'hDB, 8'h2A};
      cycle(4'b1111, 32'h0, 1'b1);
      chk("fair_id", res_id, i % 4);
      chk("fair_data", res_data, fexp[i]);
    end
    cycle(4'b0000, 32'h0, 1'b1);

    // backpressure with requester 2 waiting
    cycle(4'b0001, 32'h0000_0055, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(4'b0100, 32'h0066_0000, 1'b0);
      chk("bp_state", 32'(dut.state_q), 2);
    end
    cycle(4'b0100, 32'h0066_0000, 1'b1);
    chk("bp_grant_id", res_id, 2);

    // reset while stalled
    cycle(4'b0001, 32'h0000_0001, 1'b0);
    chk("pre_rst_busy", busy, 1);
    rst_n     = 1'b0;
    req_valid = 4'b1010;
    #1;
    chk("mid_rst_valid", res_valid, 0);
    chk("mid_rst_data", res_data, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", req_ready, 0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cycle(4'b1010, 32'h0000_0100, 1'b1);
    chk("post_rst_id", res_id, 1);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cycle(4'($urandom), $urandom, 1'($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/offset_add_sched.md
Name: offset_add_sched

Overview:
- Shares one W-bit constant-offset adder between four requesters.
- Each requester has a fixed offset derived from parameter P, using the same parameter-derivation chain as the task/function test modules.
- A round-robin arbiter grants one request per cycle. The adder result is registered into a one-entry output stage that supports backpressure.
- Sits between four independent producers and one consumer of offset-adjusted bytes.

Parameters:
- P, 23, base parameter; all offsets derive from it.
- W, 8, data width of requests and results.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_valid  input  4  per-requester request valid.
- req_data  input  4*W  per-requester operand; requester i occupies bits [i*W +: W].
- req_ready  output  4  per-requester grant/accept; at most one bit set.
- res_valid  output  1  result register holds valid data.
- res_data  output  W  registered sum.
- res_id  output  2  index of the requester that produced res_data.
- res_ready  input  1  consumer accepts the result.
- busy  output  1  high when state is not IDLE.

Behaviour:
- Offsets are computed as 32-bit integers, then truncated to W bits:
  - OFF0 = 42
  - OFF1 = P+42
  - OFF2 = P
  - OFF3 = ((P+13)-37) ^ (P+13)
  - With P=23: 0x2A, 0x41, 0x17, 0xDB.
- Sum = (req_data[i] + OFFi) mod 2^W. The carry is discarded in the default build.
- Reset (asynchronous, rst_n=0):
  - res_valid=0, res_data=0, res_id=0, rr_ptr=0, state=IDLE.
  - req_ready is combinational and forced to 0 while rst_n=0.
- State machine (state register, 2 bits):
  - IDLE: output empty, no request. Goes to FULL if any req_valid.
  - FULL: output holds a result.
    - Goes to STALL if res_ready=0.
    - Stays in FULL if res_ready=1 and a new grant occurs in the same cycle.
    - Goes to IDLE if res_ready=1 and there is no request.
  - STALL: result held with res_ready low. Goes to FULL or IDLE on res_ready=1, under the same rules as FULL.
- Accept condition: can_accept = !res_valid || res_ready.
  - When can_accept, the grant goes to the first valid requester scanning rr_ptr, rr_ptr+1, ... (mod 4).
  - req_ready[g] = 1 for that requester only. This is combinational from req_valid, rr_ptr and the state.
- Handshake and latency:
  - A transfer occurs when req_valid[g] && req_ready[g].
  - On the next edge: res_data = sum, res_id = g, res_valid = 1, rr_ptr = g+1 mod 4.
  - Latency is 1 cycle from request handshake to res_valid.
- Simultaneous drain and grant: if res_ready and res_valid are high together with a new grant, the result register reloads in the same cycle (full throughput, 1 result/cycle).
- Backpressure (res_valid=1, res_ready=0):
  - res_data and res_id hold stable; all req_ready = 0.
  - rr_ptr does not advance.
- Requesters may drop req_valid without a handshake; no grant is recorded.
- rr_ptr changes only on a grant. Wrap-around goes 3 -> 0.

Optional Feature:
- Macro: OFFSET_ADD_SATURATE_EN.
- Defined: the adder is W+1 bits wide. If the carry is set, res_data = {W{1'b1}}. A sticky output port sat_flag (1 bit, reset 0) sets on any saturating result and clears only on reset.
- Undefined: modulo-2^W wrap and no sat_flag port.

Decomposition:
- Package offset_add_pkg holds:
  - the offset-derivation function off_of(idx, P) returning an integer;
  - the state enum typedef {IDLE, FULL, STALL};
  - localparam NREQ = 4.
- Sub-module rr_arbiter4: inputs req[3:0], ptr[1:0], en; outputs grant[3:0], gidx[1:0]; purely combinational. rr_ptr stays in the top.

Test Plan:
- Single request: req0 data 0x10, res_ready=1 -> one cycle later res_valid=1, res_data=0x3A, res_id=0; req_ready=0001 in the handshake cycle.
- Offset 3 check: req3 data 0x30 -> res_data=0x0B, res_id=3. With OFFSET_ADD_SATURATE_EN: 0xFF, sat_flag=1.
- Wrap: req1 data 0xF0 -> res_data=0x31. With OFFSET_ADD_SATURATE_EN: 0xFF.
- Fairness: all four valid continuously, data 0x00, res_ready=1 -> res_id sequence 0,1,2,3,0 on consecutive cycles; res_data 0x2A, 0x41, 0x17, 0xDB, 0x2A.
- Backpressure: res_ready=0 for 3 cycles while req2 is valid -> res_data/res_id stable, req_ready=0000, state STALL. On res_ready=1, req2 is granted the same cycle.
- Reset mid-operation: assert rst_n=0 while in STALL -> res_valid=0, res_data=0, busy=0 immediately. After release, the first grant goes to the lowest valid index ≥0.
